// File: rtl/sr_flip_flop.sv
// Bank of WIDTH independent clocked SR cells with synchronous active-high reset.
// s=r=1 is a defined hold, and q_bar is always the complement of the single state register.
module sr_flip_flop #(
   parameter int unsigned           WIDTH       = 1,
   parameter logic [WIDTH-1:0]      RESET_VALUE = '0
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [WIDTH-1:0] s,
   input  logic [WIDTH-1:0] r,
   output logic [WIDTH-1:0] q,
   output logic [WIDTH-1:0] q_bar
);

   logic [WIDTH-1:0] q_q;
   logic [WIDTH-1:0] q_d;

   // Set only where s alone is asserted, clear only where r alone is asserted.
   // Every other combination, including s=r=1, keeps the current value.
   always_comb begin
      q_d = q_q;
      q_d = (q_q & ~(r & ~s)) | (s & ~r);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         q_q <= RESET_VALUE;
      end else begin
         q_q <= q_d;
      end
   end

   assign q     = q_q;
   assign q_bar = ~q_q;

endmodule

// File: tb/tb_sr_flip_flop.sv
// Scoreboard bench for sr_flip_flop: a 1-bit instance with the default reset value,
// and a 4-bit instance with a non-zero reset value driven with mixed per-bit s/r.
module tb_sr_flip_flop;

   typedef struct {
      logic       e1;
      logic [3:0] e4;
   } exp_t;

   logic       clk;
   logic       reset;
   logic [0:0] s1, r1, q1, qb1;
   logic [3:0] s4, r4, q4, qb4;

   exp_t sb[$];
   int   checks;
   int   errors;

   sr_flip_flop u_dut1 (
      .clk   (clk),
      .reset (reset),
      .s     (s1),
      .r     (r1),
      .q     (q1),
      .q_bar (qb1)
   );

   sr_flip_flop #(
      .WIDTH       (4),
      .RESET_VALUE (4'b0110)
   ) u_dut4 (
      .clk   (clk),
      .reset (reset),
      .s     (s4),
      .r     (r4),
      .q     (q4),
      .q_bar (qb4)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [3:0] act, input logic [3:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
      end
   endtask

   // Monitor: each rising edge presents a new q; compare just after the edge and
   // again just before the next edge, after any mid-cycle input activity.
   initial begin
      exp_t e;
      forever begin
         @(posedge clk);
         #1;
         if (sb.size() != 0) begin
            e = sb.pop_front();
            chk("q1_edge",     {3'b000, q1},  {3'b000, e.e1});
            chk("q_bar1_edge", {3'b000, qb1}, {3'b000, ~e.e1});
            chk("q4_edge",     q4,  e.e4);
            chk("q_bar4_edge", qb4, ~e.e4);
            #7;
            chk("q1_stable",     {3'b000, q1},  {3'b000, e.e1});
            chk("q_bar1_stable", {3'b000, qb1}, {3'b000, ~e.e1});
            chk("q4_stable",     q4,  e.e4);
            chk("q_bar4_stable", qb4, ~e.e4);
         end
      end
   end

   // Drive one sampling edge; optionally wiggle every input after that edge in the
   // direction that would change q, then restore, to prove nothing moves between edges.
   task automatic step(input logic rst, input logic si1, input logic ri1,
                       input logic [3:0] si4, input logic [3:0] ri4,
                       input logic e1, input logic [3:0] e4, input logic glitch);
      exp_t e;
      @(negedge clk);
      reset = rst;
      s1    = si1;
      r1    = ri1;
      s4    = si4;
      r4    = ri4;
      e.e1  = e1;
      e.e4  = e4;
      sb.push_back(e);
      @(posedge clk);
      if (glitch) begin
         #2;
         reset = ~rst;
         s1    = ~e1;
         r1    = e1;
         s4    = ~e4;
         r4    = e4;
         #2;
         reset = rst;
         s1    = si1;
         r1    = ri1;
         s4    = si4;
         r4    = ri4;
      end
   endtask

   initial begin
      int unsigned wait_cycles;
      checks = 0;
      errors = 0;
      reset  = 1'b0;
      s1     = '0;
      r1     = '0;
      s4     = '0;
      r4     = '0;
      repeat (2) @(posedge clk);

      //    rst  s1    r1    s4       r4       e1    e4       glitch
      step(1'b1, 1'b0, 1'b0, 4'b0000, 4'b0000, 1'b0, 4'b0110, 1'b0);
      step(1'b1, 1'b1, 1'b0, 4'b1111, 4'b0000, 1'b0, 4'b0110, 1'b0);
      step(1'b0, 1'b1, 1'b0, 4'b0011, 4'b0101, 1'b1, 4'b0010, 1'b0);
      step(1'b0, 1'b0, 1'b1, 4'b1100, 4'b0000, 1'b0, 4'b1110, 1'b0);
      step(1'b0, 1'b0, 1'b1, 4'b0000, 4'b0000, 1'b0, 4'b1110, 1'b0);
      step(1'b0, 1'b1, 1'b1, 4'b1111, 4'b1111, 1'b0, 4'b1110, 1'b0);
      step(1'b0, 1'b1, 1'b1, 4'b1111, 4'b1111, 1'b0, 4'b1110, 1'b0);
      step(1'b0, 1'b1, 1'b0, 4'b0000, 4'b1010, 1'b1, 4'b0100, 1'b0);
      step(1'b0, 1'b1, 1'b1, 4'b0011, 4'b0011, 1'b1, 4'b0100, 1'b0);
      step(1'b0, 1'b1, 1'b1, 4'b0011, 4'b0011, 1'b1, 4'b0100, 1'b0);
      step(1'b0, 1'b0, 1'b0, 4'b0000, 4'b0000, 1'b1, 4'b0100, 1'b1);
      step(1'b0, 1'b0, 1'b0, 4'b0000, 4'b0000, 1'b1, 4'b0100, 1'b1);
      step(1'b1, 1'b1, 1'b0, 4'b1111, 4'b0000, 1'b0, 4'b0110, 1'b1);
      step(1'b1, 1'b1, 1'b0, 4'b1111, 4'b0000, 1'b0, 4'b0110, 1'b0);
      step(1'b0, 1'b1, 1'b0, 4'b1001, 4'b0110, 1'b1, 4'b1001, 1'b0);
      step(1'b0, 1'b0, 1'b1, 4'b0000, 4'b1111, 1'b0, 4'b0000, 1'b0);
      step(1'b0, 1'b0, 1'b0, 4'b0000, 4'b0000, 1'b0, 4'b0000, 1'b1);

      wait_cycles = 0;
      while (sb.size() != 0 && wait_cycles < 20) begin
         @(posedge clk);
         wait_cycles++;
      end
      if (sb.size() != 0) begin
         errors++;
         $display("FAIL drain: %0d entries left, required 0", sb.size());
      end
      repeat (2) @(posedge clk);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
